writeback_unit: RTL
===================

Name: writeback_unit

Overview:
- Pipelined write-back stage for the MIPS core; successor to the combinational write-back data selector.
- Registers the MEM/WB payload and waits on a variable-latency memory load response using a valid/ready handshake.
- Applies byte/halfword alignment and sign/zero extension for LB/LBU/LH/LHU/LW.
- Drives the register-file write port with registered outputs.

Parameters:
- REG_AW, 5, register-file address width.
- BIG_ENDIAN, 0, 0 = little-endian byte lanes, 1 = big-endian byte lanes.
- TIMEOUT_CYCLES, 16, load-response timeout limit (used only with WB_LOAD_TIMEOUT_EN).

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  MEM/WB payload valid.
- in_ready  output  1  stage can accept a payload.
- in_instruction  input  32  instruction word; opcode = bits [31:26].
- in_alu_out  input  32  ALU result, or effective address for loads.
- in_dest  input  REG_AW  destination register.
- mem_rsp_valid  input  1  load data valid.
- mem_rsp_data  input  32  raw aligned memory word.
- wb_en  output  1  register-file write enable, one-cycle pulse.
- wb_addr  output  REG_AW  write address.
- wb_data  output  32  write data.
- misalign  output  1  one-cycle pulse on a misaligned load.
- busy  output  1  a load is outstanding.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: wb_en=0, wb_addr=0, wb_data=0, misalign=0, busy=0. State returns to IDLE and any latched payload is discarded. This holds for reset mid-WAIT as well; a later mem_rsp_valid is then ignored.
- Load opcodes: LB=0x20, LH=0x21, LW=0x23, LBU=0x24, LHU=0x25. Every other opcode is a non-load.
- Byte offset off = in_alu_out[1:0].
- State IDLE:
  - in_ready=1; accept on in_valid && in_ready.
  - Non-load accepted: next cycle wb_en=1, wb_addr=in_dest, wb_data=in_alu_out. Stay IDLE, so back-to-back non-loads give 1 writeback/cycle.
  - Load accepted: latch opcode, off and dest; go to WAIT. wb_en=0 next cycle.
  - Misaligned load accepted (LW with off!=0; LH/LHU with off[0]=1): no memory wait and no write. Next cycle misalign=1, wb_en=0. Stay IDLE.
- State WAIT:
  - in_ready=0, busy=1.
  - On mem_rsp_valid: next cycle wb_en=1, wb_addr=latched dest, wb_data=extended data. Return to IDLE; in_ready=1 in that same cycle.
- Extension, little-endian:
  - Byte lane k = data[8k+7:8k].
  - Halfword at off=0 is [15:0]; at off=2 it is [31:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- BIG_ENDIAN=1: byte lane index = 3-off; halfword at off=0 is [31:16].
- Register 0: wb_en is forced 0 when the destination is 0. The stage still consumes the load response. wb_data/wb_addr update anyway.
- mem_rsp_valid in IDLE, or in the same cycle a load is accepted, is ignored.
- When wb_en=0, wb_addr and wb_data hold their previous values.
- Latency:
  - Non-load: 1 cycle.
  - Load: response cycle + 1.

Optional Feature:
- Macro WB_LOAD_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without a response.
  - On reaching TIMEOUT_CYCLES: return to IDLE and pulse output load_timeout (1 bit, reset 0) for one cycle. wb_en=0.
  - A response arriving in the same cycle as the limit wins: normal writeback, no timeout.
- Not defined:
  - The load_timeout port and counter are absent.
  - WAIT holds indefinitely until mem_rsp_valid.

Test Plan:
- Non-load back-to-back: ADDU-type payloads, dest 3 then dest 4, alu 0x11/0x22 on consecutive cycles -> wb_en high two consecutive cycles, (3,0x11) then (4,0x22), in_ready stays 1.
- LB sign-extend: off=1, response 0x0000_8000 after 3 wait cycles, dest 5 -> busy 3+ cycles, then wb_en=1, wb_data=0xFFFF_FF80; with LBU -> 0x0000_0080.
- LH/LHU off=2, response 0x9ABC_1234 -> LH 0xFFFF_9ABC, LHU 0x0000_9ABC. With BIG_ENDIAN=1, LH off=2 -> 0x0000_1234.
- Misaligned LW off=2 -> misalign pulse 1 cycle, wb_en=0, busy=0. Following ADDU is accepted on the next cycle.
- Load to dest 0 with a response -> wb_en stays 0 and the stage returns to IDLE. Reset asserted during WAIT -> all outputs 0; a later stray mem_rsp_valid produces no write.
- WB_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4, no response -> load_timeout pulse after 4 WAIT cycles, wb_en=0, in_ready=1. A response exactly on cycle 4 gives a normal writeback.

Source files
------------

// File: rtl/writeback_unit_if.sv
// Handshake and register-file write bundle between the MEM/WB pipeline register,
// the load-response path and the write-back stage.
interface writeback_unit_if #(
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instruction;
    logic [31:0]       in_alu_out;
    logic [REG_AW-1:0] in_dest;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rsp_data;
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [31:0]       wb_data;
    logic              misalign;
    logic              busy;

    modport master (
        output in_valid, in_instruction, in_alu_out, in_dest,
        output mem_rsp_valid, mem_rsp_data,
        input  in_ready, wb_en, wb_addr, wb_data, misalign, busy
    );

    modport slave (
        input  in_valid, in_instruction, in_alu_out, in_dest,
        input  mem_rsp_valid, mem_rsp_data,
        output in_ready, wb_en, wb_addr, wb_data, misalign, busy
    );
endinterface

// File: rtl/writeback_unit.sv
// MIPS write-back stage: waits on load responses, aligns and extends load data.
// Optional macro WB_LOAD_TIMEOUT_EN adds a load-response timeout and load_timeout pulse.
module writeback_unit #(
    parameter int REG_AW         = 5,
    parameter bit BIG_ENDIAN     = 1'b0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    writeback_unit_if.slave   bus
`ifdef WB_LOAD_TIMEOUT_EN
    ,
    output logic              load_timeout
`endif
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    typedef enum logic [0:0] {IDLE, WAIT} state_t;

    state_t            state_q;
    logic [5:0]        op_q;
    logic [1:0]        off_q;
    logic [REG_AW-1:0] dest_q;
    logic              wb_en_q;
    logic [REG_AW-1:0] wb_addr_q;
    logic [31:0]       wb_data_q;
    logic              misalign_q;

    logic [5:0]  in_op;
    logic [1:0]  in_off;
    logic        in_is_load;
    logic        in_misaligned;
    logic [7:0]  lane [4];
    logic [1:0]  byte_sel;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data_d;

    assign in_op  = bus.in_instruction[31:26];
    assign in_off = bus.in_alu_out[1:0];

    assign in_is_load = (in_op == OP_LB) || (in_op == OP_LH) || (in_op == OP_LW) ||
                        (in_op == OP_LBU) || (in_op == OP_LHU);
    assign in_misaligned = ((in_op == OP_LW) && (in_off != 2'd0)) ||
                           (((in_op == OP_LH) || (in_op == OP_LHU)) && in_off[0]);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = bus.mem_rsp_data[8*gi +: 8];
        end
    endgenerate

    // Big-endian mirrors the lane order: byte lane 3-off, and the upper half at off=0.
    assign byte_sel = BIG_ENDIAN ? (2'd3 - off_q) : off_q;
    assign sel_byte = lane[byte_sel];
    assign sel_half = (off_q[1] ^ BIG_ENDIAN) ? bus.mem_rsp_data[31:16] : bus.mem_rsp_data[15:0];

    always_comb begin
        ext_data_d = bus.mem_rsp_data;
        case (op_q)
            OP_LB:   ext_data_d = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  ext_data_d = {24'h0, sel_byte};
            OP_LH:   ext_data_d = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  ext_data_d = {16'h0, sel_half};
            default: ext_data_d = bus.mem_rsp_data;
        endcase
    end

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= 6'h0;
            off_q      <= 2'd0;
            dest_q     <= '0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= 32'h0;
            misalign_q <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            wb_en_q    <= 1'b0;
            misalign_q <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    // Any response seen here belongs to no outstanding load and is dropped.
                    if (bus.in_valid) begin
                        if (!in_is_load) begin
                            wb_en_q   <= (bus.in_dest != '0);
                            wb_addr_q <= bus.in_dest;
                            wb_data_q <= bus.in_alu_out;
                        end else if (in_misaligned) begin
                            misalign_q <= 1'b1;
                        end else begin
                            op_q    <= in_op;
                            off_q   <= in_off;
                            dest_q  <= bus.in_dest;
                            state_q <= WAIT;
`ifdef WB_LOAD_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end
                    end
                end
                WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        wb_en_q   <= (dest_q != '0);
                        wb_addr_q <= dest_q;
                        wb_data_q <= ext_data_d;
                        state_q   <= IDLE;
                    end
`ifdef WB_LOAD_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q == WAIT);
    assign bus.wb_en    = wb_en_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.misalign = misalign_q;
`ifdef WB_LOAD_TIMEOUT_EN
    assign load_timeout = timeout_q;
`endif
endmodule
